// File: rtl/fetch_responder_if.sv
// fetch_responder_if
//   Groups the request, register-source, memory-bus and response signals of
//   the fetch read channel.
//   master : the surrounding environment (fetcher, register file, memory map)
//   slave  : the responder
//   Signals:
//     req / req_sel / req_addr / req_ready : tagged request handshake
//     x_reg / y_reg                        : register sources
//     mem_rd / mem_addr / mem_rdata / mem_ready : external ready/wait read bus
//     rsp_valid / rsp_data / rsp_err       : one-byte response per request
interface fetch_responder_if #(
  parameter int REG_WIDTH  = 8,
  parameter int ADDR_WIDTH = 16
);
  logic                  req;
  logic [3:0]            req_sel;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  req_ready;
  logic [REG_WIDTH-1:0]  x_reg;
  logic [REG_WIDTH-1:0]  y_reg;
  logic                  mem_rd;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [REG_WIDTH-1:0]  mem_rdata;
  logic                  mem_ready;
  logic                  rsp_valid;
  logic [REG_WIDTH-1:0]  rsp_data;
  logic                  rsp_err;

  modport master (
    output req, req_sel, req_addr, x_reg, y_reg, mem_rdata, mem_ready,
    input  req_ready, mem_rd, mem_addr, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req, req_sel, req_addr, x_reg, y_reg, mem_rdata, mem_ready,
    output req_ready, mem_rd, mem_addr, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/fetch_responder.sv
// fetch_responder
//   In-order read responder for the instruction fetcher. Requests are queued
//   in a 2-entry FIFO and serviced from the head: register selectors answer on
//   the next edge, memory selectors wait on mem_ready with a bounded timeout,
//   anything else answers with an error. Exactly one response per accepted
//   request.
//   Ports:
//     phi1  : clock, rising edge
//     reset : asynchronous active-high reset
//     bus   : fetch_responder_if.slave (request, register, memory, response)
module fetch_responder #(
  parameter int         REG_WIDTH  = 8,
  parameter int         ADDR_WIDTH = 16,
  parameter int         TIMEOUT    = 15,
  parameter logic [3:0] SEL_MEM    = 4'd1,
  parameter logic [3:0] SEL_X      = 4'd2,
  parameter logic [3:0] SEL_Y      = 4'd3
) (
  input  logic              phi1,
  input  logic              reset,
  fetch_responder_if.slave  bus
);

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  logic [1:0]            r_count;
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [3:0]            r_sel  [2];
  logic [ADDR_WIDTH-1:0] r_addr [2];
  logic [7:0]            r_wait;
  logic                  r_rsp_valid;
  logic [REG_WIDTH-1:0]  r_rsp_data;
  logic                  r_rsp_err;

  logic                  w_busy;
  logic                  w_head_mem;
  logic                  w_timeout;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_err;
  logic [REG_WIDTH-1:0]  w_data;
  logic [3:0]            w_head_sel;
  logic [ADDR_WIDTH-1:0] w_head_addr;

  assign w_head_sel  = r_sel[r_rd_ptr];
  assign w_head_addr = r_addr[r_rd_ptr];
  assign w_busy      = (r_count != 2'd0);
  assign w_head_mem  = w_busy && (w_head_sel == SEL_MEM);
  assign w_timeout   = (r_wait == WAIT_LAST);

  // Ready depends on occupancy only, so a same-edge pop does not open a slot.
  assign bus.req_ready = (r_count < 2'd2);
  assign w_push        = bus.req && bus.req_ready;

  // Memory strobe follows the head combinationally, so clearing count on
  // reset drops it immediately.
  assign bus.mem_rd   = w_head_mem;
  assign bus.mem_addr = w_head_mem ? w_head_addr : '0;

  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_err   = r_rsp_err;

  // Head service decision: whether the head completes on this edge and with
  // which byte. mem_ready takes priority over the timeout.
  always_comb begin
    w_pop  = 1'b0;
    w_data = '0;
    w_err  = 1'b0;
    if (w_busy) begin
      if (w_head_sel == SEL_X) begin
        w_pop  = 1'b1;
        w_data = bus.x_reg;
      end else if (w_head_sel == SEL_Y) begin
        w_pop  = 1'b1;
        w_data = bus.y_reg;
      end else if (w_head_sel == SEL_MEM) begin
        if (bus.mem_ready) begin
          w_pop  = 1'b1;
          w_data = bus.mem_rdata;
        end else if (w_timeout) begin
          w_pop  = 1'b1;
          w_data = '1;
          w_err  = 1'b1;
        end
      end else begin
        w_pop = 1'b1;
        w_err = 1'b1;
      end
    end
  end

  // Control and response registers
  always_ff @(posedge phi1 or posedge reset) begin
    if (reset) begin
      r_count     <= 2'd0;
      r_wr_ptr    <= 1'b0;
      r_rd_ptr    <= 1'b0;
      r_wait      <= 8'd0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      // Counter only advances while a memory read is outstanding.
      if (w_pop || !w_head_mem) r_wait <= 8'd0;
      else                      r_wait <= r_wait + 8'd1;
      r_rsp_valid <= w_pop;
      if (w_pop) begin
        r_rsp_data <= w_data;
        r_rsp_err  <= w_err;
      end
    end
  end

  // Queue storage; contents are only meaningful while counted.
  always_ff @(posedge phi1) begin
    if (w_push) begin
      r_sel[r_wr_ptr]  <= bus.req_sel;
      r_addr[r_wr_ptr] <= bus.req_addr;
    end
  end

endmodule

// File: tb/tb_fetch_responder.sv
module tb_fetch_responder;
  localparam int         TIMEOUT = 15;
  localparam logic [3:0] SEL_MEM = 4'd1;
  localparam logic [3:0] SEL_X   = 4'd2;
  localparam logic [3:0] SEL_Y   = 4'd3;

  logic phi1;
  logic reset;

  fetch_responder_if #(.REG_WIDTH(8), .ADDR_WIDTH(16)) bus ();

  fetch_responder #(
    .REG_WIDTH(8), .ADDR_WIDTH(16), .TIMEOUT(TIMEOUT),
    .SEL_MEM(SEL_MEM), .SEL_X(SEL_X), .SEL_Y(SEL_Y)
  ) dut (
    .phi1 (phi1),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial phi1 = 1'b0;
  always #5 phi1 = ~phi1;

  int total = 0;
  int bad   = 0;
  int n_rsp = 0;

  // Reference model: list of pending requests plus elapsed wait cycles of the
  // head memory read, and the last response expected on the channel.
  typedef struct {
    logic [3:0]  sel;
    logic [15:0] addr;
  } req_t;
  req_t       mq[$];
  int         m_wait = 0;
  logic       exp_valid = 1'b0;
  logic [7:0] exp_data  = 8'h00;
  logic       exp_err   = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_wait    = 0;
    exp_valid = 1'b0;
    exp_data  = 8'h00;
    exp_err   = 1'b0;
  endtask

  // One clock: check combinational outputs before the edge, advance the
  // model across the edge, check registered outputs just after it.
  task automatic tick();
    bit         pop;
    bit         accept;
    logic [7:0] d;
    logic       e;
    req_t       r;
    pop = 0; d = 8'h00; e = 1'b0;
    chk("req_ready", {31'd0, bus.req_ready}, {31'd0, (mq.size() < 2)});
    chk("mem_rd", {31'd0, bus.mem_rd}, {31'd0, (mq.size() > 0 && mq[0].sel == SEL_MEM)});
    chk("mem_addr", {16'd0, bus.mem_addr},
        (mq.size() > 0 && mq[0].sel == SEL_MEM) ? {16'd0, mq[0].addr} : 32'd0);
    if (mq.size() > 0) begin
      if (mq[0].sel == SEL_X) begin
        pop = 1; d = bus.x_reg;
      end else if (mq[0].sel == SEL_Y) begin
        pop = 1; d = bus.y_reg;
      end else if (mq[0].sel == SEL_MEM) begin
        if (bus.mem_ready) begin
          pop = 1; d = bus.mem_rdata;
        end else if (m_wait == TIMEOUT - 1) begin
          pop = 1; d = 8'hFF; e = 1'b1;
        end
      end else begin
        pop = 1; d = 8'h00; e = 1'b1;
      end
    end
    accept = bus.req && (mq.size() < 2);
    r.sel  = bus.req_sel;
    r.addr = bus.req_addr;
    @(posedge phi1);
    #1;
    exp_valid = pop;
    if (pop) begin
      void'(mq.pop_front());
      m_wait   = 0;
      exp_data = d;
      exp_err  = e;
    end else if (mq.size() > 0 && mq[0].sel == SEL_MEM) begin
      m_wait++;
    end
    if (accept) mq.push_back(r);
    if (bus.rsp_valid === 1'b1) n_rsp++;
    chk("rsp_valid", {31'd0, bus.rsp_valid}, {31'd0, exp_valid});
    chk("rsp_data", {24'd0, bus.rsp_data}, {24'd0, exp_data});
    chk("rsp_err", {31'd0, bus.rsp_err}, {31'd0, exp_err});
  endtask

  task automatic drive_req(input logic v, input logic [3:0] s, input logic [15:0] a);
    bus.req      = v;
    bus.req_sel  = s;
    bus.req_addr = a;
  endtask

  initial begin
    int   lat;
    int   base;
    int   mode;
    int   k;
    reset         = 1'b1;
    bus.req       = 1'b0;
    bus.req_sel   = 4'd0;
    bus.req_addr  = 16'h0000;
    bus.x_reg     = 8'h00;
    bus.y_reg     = 8'h00;
    bus.mem_rdata = 8'h00;
    bus.mem_ready = 1'b0;
    model_clear();

    // Reset values
    #2;
    chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst_rsp_data", {24'd0, bus.rsp_data}, 32'd0);
    chk("rst_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
    chk("rst_mem_rd", {31'd0, bus.mem_rd}, 32'd0);
    chk("rst_mem_addr", {16'd0, bus.mem_addr}, 32'd0);
    chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    @(posedge phi1);
    #2 reset = 1'b0;

    // Register read: X
    bus.x_reg = 8'h3C;
    drive_req(1'b1, SEL_X, 16'h0000);
    tick();
    drive_req(1'b0, 4'd0, 16'h0000);
    chk("x_no_early", {31'd0, bus.rsp_valid}, 32'd0);
    tick();
    chk("x_valid", {31'd0, bus.rsp_valid}, 32'd1);
    chk("x_data", {24'd0, bus.rsp_data}, 32'h3C);
    chk("x_err", {31'd0, bus.rsp_err}, 32'd0);
    tick();

    // Memory read with three wait cycles
    base = n_rsp;
    drive_req(1'b1, SEL_MEM, 16'h8001);
    tick();
    drive_req(1'b0, 4'd0, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      chk("mem_addr_wait", {16'd0, bus.mem_addr}, 32'h8001);
      tick();
    end
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 8'hA9;
    tick();
    chk("mem_valid", {31'd0, bus.rsp_valid}, 32'd1);
    chk("mem_data", {24'd0, bus.rsp_data}, 32'hA9);
    bus.mem_ready = 1'b0;
    tick();
    tick();
    chk("mem_one_rsp", n_rsp - base, 32'd1);

    // Memory timeout
    drive_req(1'b1, SEL_MEM, 16'h1234);
    tick();
    drive_req(1'b0, 4'd0, 16'h0000);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (bus.rsp_valid === 1'b1 && lat == 0) lat = i;
    end
    chk("timeout_latency", lat, TIMEOUT);
    chk("timeout_data", {24'd0, bus.rsp_data}, 32'hFF);
    chk("timeout_err", {31'd0, bus.rsp_err}, 32'd1);
    chk("timeout_mem_rd_low", {31'd0, bus.mem_rd}, 32'd0);

    // Full queue: third request ignored
    base = n_rsp;
    bus.y_reg = 8'h07;
    drive_req(1'b1, SEL_MEM, 16'h0010);
    tick();
    drive_req(1'b1, SEL_Y, 16'h0000);
    tick();
    drive_req(1'b1, SEL_X, 16'h0000);
    chk("full_not_ready", {31'd0, bus.req_ready}, 32'd0);
    tick();
    drive_req(1'b0, 4'd0, 16'h0000);
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 8'h5A;
    tick();
    chk("full_rsp1", {24'd0, bus.rsp_data}, 32'h5A);
    bus.mem_ready = 1'b0;
    tick();
    chk("full_rsp2", {24'd0, bus.rsp_data}, 32'h07);
    for (int i = 0; i < 4; i++) tick();
    chk("full_two_rsp", n_rsp - base, 32'd2);

    // Illegal selector then Y
    bus.y_reg = 8'h55;
    drive_req(1'b1, 4'd0, 16'h0000);
    tick();
    drive_req(1'b1, SEL_Y, 16'h0000);
    tick();
    drive_req(1'b0, 4'd0, 16'h0000);
    chk("ill_valid", {31'd0, bus.rsp_valid}, 32'd1);
    chk("ill_data", {24'd0, bus.rsp_data}, 32'h00);
    chk("ill_err", {31'd0, bus.rsp_err}, 32'd1);
    tick();
    chk("ill_next_valid", {31'd0, bus.rsp_valid}, 32'd1);
    chk("ill_next_data", {24'd0, bus.rsp_data}, 32'h55);
    chk("ill_next_err", {31'd0, bus.rsp_err}, 32'd0);
    tick();

    // Asynchronous reset with a waiting memory read and a queued entry
    base = n_rsp;
    drive_req(1'b1, SEL_MEM, 16'h4444);
    tick();
    drive_req(1'b1, SEL_X, 16'h0000);
    tick();
    drive_req(1'b0, 4'd0, 16'h0000);
    chk("pre_rst_mem_rd", {31'd0, bus.mem_rd}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_mem_rd", {31'd0, bus.mem_rd}, 32'd0);
    chk("async_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("async_req_ready", {31'd0, bus.req_ready}, 32'd1);
    model_clear();
    #1 reset = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("rst_no_rsp", n_rsp - base, 32'd0);
    bus.x_reg = 8'hC3;
    drive_req(1'b1, SEL_X, 16'h0000);
    tick();
    drive_req(1'b0, 4'd0, 16'h0000);
    tick();
    chk("post_rst_x", {24'd0, bus.rsp_data}, 32'hC3);
    chk("post_rst_valid", {31'd0, bus.rsp_valid}, 32'd1);

    // Randomized traffic
    mode = 0;
    for (int c = 0; c < 800; c++) begin
      if (c % 50 == 0) mode = $urandom_range(0, 2);
      k = $urandom_range(0, 7);
      bus.req      = ($urandom_range(0, 2) != 0);
      bus.req_sel  = (k <= 2) ? SEL_MEM : (k == 3) ? SEL_X : (k == 4) ? SEL_Y :
                     (k == 5) ? 4'd0 : 4'($urandom_range(0, 15));
      bus.req_addr = 16'($urandom);
      bus.x_reg    = 8'($urandom);
      bus.y_reg    = 8'($urandom);
      bus.mem_rdata = 8'($urandom);
      bus.mem_ready = (mode == 0) ? ($urandom_range(0, 3) == 0) :
                      (mode == 1) ? 1'b0 : 1'b1;
      tick();
    end
    drive_req(1'b0, 4'd0, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
